// File: rtl/periph_interconnect.sv
// Peripheral interconnect: decodes the host address slot field into a one-hot slave select,
// waits for the selected slave's ready with a timeout, and reports bus errors through slot 0.
module periph_interconnect #(
   parameter int unsigned          NUM_SLOTS  = 16,
   parameter int unsigned          ADDR_WIDTH = 14,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          OFFS_BITS  = 8,
   parameter int unsigned          SLOT_BITS  = 5,
   parameter logic [NUM_SLOTS-1:0] SLOT_MASK  = 16'h03FE,
   parameter int unsigned          TIMEOUT    = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ADDR_WIDTH-1:0]           address,
   input  logic [DATA_WIDTH-1:0]           write_data,
   output logic [DATA_WIDTH-1:0]           read_data,
   input  logic                            we,
   input  logic                            re,
   output logic                            ready,
   output logic                            error,
   output logic                            busy,
   output logic [NUM_SLOTS-1:0]            slv_sel,
   output logic                            slv_we,
   output logic                            slv_re,
   output logic [OFFS_BITS-1:0]            slv_address,
   output logic [DATA_WIDTH-1:0]           slv_write_data,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slv_read_data,
   input  logic [NUM_SLOTS-1:0]            slv_ready
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    wr_q, wr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   err_count_q, err_count_d;
   logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

   logic [SLOT_BITS-1:0]    req_slot;
   logic [OFFS_BITS-1:0]    req_offs;
   logic                    req_ext;
   logic [DATA_WIDTH-1:0]   int_rdata;
   logic [SLOT_BITS-1:0]    cur_slot;
   logic [NUM_SLOTS-1:0]    cur_oh;
   logic                    cur_rdy;
   logic [DATA_WIDTH-1:0]   cur_rdata;

   assign req_slot = address[OFFS_BITS+SLOT_BITS-1:OFFS_BITS];
   assign req_offs = address[OFFS_BITS-1:0];
   assign cur_slot = addr_q[OFFS_BITS+SLOT_BITS-1:OFFS_BITS];

   // Decode of the incoming request: populated external slot and slot-0 register read value
   always_comb begin
      req_ext = 1'b0;
      for (int unsigned i = 1; i < NUM_SLOTS; i++) begin
         if (req_slot == SLOT_BITS'(i) && SLOT_MASK[i]) begin
            req_ext = 1'b1;
         end
      end
      int_rdata = '0;
      if (req_offs == OFFS_BITS'(0)) begin
         int_rdata = err_count_q;
      end else if (req_offs == OFFS_BITS'(4)) begin
         int_rdata = DATA_WIDTH'(err_addr_q);
      end
   end

   // Select, ready and read-data mux for the latched slot
   always_comb begin
      cur_oh    = '0;
      cur_rdy   = 1'b0;
      cur_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (cur_slot == SLOT_BITS'(i)) begin
            cur_oh[i] = 1'b1;
            cur_rdy   = slv_ready[i];
            cur_rdata = slv_read_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      unique case (state_q)
         IDLE: begin
            if (we || re) begin
               addr_d  = address;
               wdata_d = write_data;
               wr_d    = we;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (we && re) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (req_slot == '0) begin
                  state_d = RESP;
                  rdata_d = re ? int_rdata : '0;
                  if (we && req_offs == OFFS_BITS'(8) && write_data[0]) begin
                     err_count_d = '0;
                     err_addr_d  = '0;
                  end
               end else if (req_ext) begin
                  state_d = ACCESS;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ACCESS: begin
            // Ready wins over timeout so a slave answering in the last allowed cycle succeeds
            if (cur_rdy) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = wr_q ? '0 : cur_rdata;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (err_q) begin
               if (err_count_q != '1) begin
                  err_count_d = err_count_q + 1'b1;
               end
               err_addr_d = addr_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
      end
   end

   // The wait counter is zero only in the first ACCESS cycle, which doubles as the strobe cycle
   assign read_data      = rdata_q;
   assign ready          = (state_q == RESP);
   assign error          = (state_q == RESP) && err_q;
   assign busy           = (state_q == ACCESS);
   assign slv_sel        = (state_q == ACCESS) ? cur_oh : '0;
   assign slv_we         = (state_q == ACCESS) && (cnt_q == '0) && wr_q;
   assign slv_re         = (state_q == ACCESS) && (cnt_q == '0) && !wr_q;
   assign slv_address    = addr_q[OFFS_BITS-1:0];
   assign slv_write_data = wdata_q;

endmodule

// File: tb/tb_periph_interconnect.sv
// Self-checking bench for periph_interconnect: directed vector table, hand-written
// busy/reset sequences, and randomized transactions against a transaction-level model.
module tb_periph_interconnect;

   localparam int NUM_SLOTS  = 16;
   localparam int ADDR_WIDTH = 14;
   localparam int DATA_WIDTH = 32;
   localparam int OFFS_BITS  = 8;
   localparam int SLOT_BITS  = 5;
   localparam int TIMEOUT    = 64;
   localparam logic [15:0] SLOT_MASK = 16'h03FE;

   logic                            clk = 1'b0;
   logic                            rst_n = 1'b0;
   logic [ADDR_WIDTH-1:0]           address = '0;
   logic [DATA_WIDTH-1:0]           write_data = '0;
   logic [DATA_WIDTH-1:0]           read_data;
   logic                            we = 1'b0;
   logic                            re = 1'b0;
   logic                            ready, error, busy;
   logic [NUM_SLOTS-1:0]            slv_sel;
   logic                            slv_we, slv_re;
   logic [OFFS_BITS-1:0]            slv_address;
   logic [DATA_WIDTH-1:0]           slv_write_data;
   logic [NUM_SLOTS*DATA_WIDTH-1:0] slv_read_data = '0;
   logic [NUM_SLOTS-1:0]            slv_ready = '0;

   periph_interconnect #(
      .NUM_SLOTS(NUM_SLOTS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .OFFS_BITS(OFFS_BITS), .SLOT_BITS(SLOT_BITS), .SLOT_MASK(SLOT_MASK), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
      .read_data(read_data), .we(we), .re(re), .ready(ready), .error(error), .busy(busy),
      .slv_sel(slv_sel), .slv_we(slv_we), .slv_re(slv_re), .slv_address(slv_address),
      .slv_write_data(slv_write_data), .slv_read_data(slv_read_data), .slv_ready(slv_ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference error registers
   logic [31:0] m_cnt  = '0;
   logic [13:0] m_addr = '0;

   typedef struct {
      logic [13:0] a;
      logic        w;
      logic        r;
      logic [31:0] wd;
      int          waits;
      logic [31:0] sd;
      int          lat;
      logic        err;
      logic [31:0] rd;
      logic        ext;
   } vec_t;

   vec_t tbl [23];

   task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   // Transaction-level reference: latency, error, read value and whether a slave is touched
   task automatic model(input logic [13:0] a, input logic w, input logic r, input logic [31:0] wd,
                        input int waits, input logic [31:0] sd,
                        output int lat, output logic e, output logic [31:0] rd, output logic ext);
      int slot, off;
      slot = (int'(a) >> OFFS_BITS) % (1 << SLOT_BITS);
      off  = int'(a) % (1 << OFFS_BITS);
      lat = 1; e = 1'b0; rd = '0; ext = 1'b0;
      if (w && r) begin
         e = 1'b1;
      end else if (slot == 0) begin
         if (r && off == 0) rd = m_cnt;
         else if (r && off == 4) rd = 32'(m_addr);
         if (w && off == 8 && wd[0]) begin
            m_cnt  = '0;
            m_addr = '0;
         end
      end else if (slot >= NUM_SLOTS || !SLOT_MASK[slot]) begin
         e = 1'b1;
      end else begin
         ext = 1'b1;
         if (waits < TIMEOUT) begin
            lat = waits + 2;
            rd  = r ? sd : '0;
         end else begin
            lat = TIMEOUT + 1;
            e   = 1'b1;
         end
      end
      if (e) begin
         if (m_cnt != '1) m_cnt = m_cnt + 1;
         m_addr = a;
      end
   endtask

   task automatic run_txn(input string tag, input logic [13:0] a, input logic w, input logic r,
                          input logic [31:0] wd, input int waits, input logic [31:0] sd, input logic dup,
                          input int e_lat, input logic e_err, input logic [31:0] e_rd, input logic e_ext);
      logic [15:0] oh;
      int          slot, k, lat, nwe, nre, nsel, nbad;
      logic        got, err_s;
      logic [31:0] rd_s, s_wd;
      logic [7:0]  s_addr;
      slot = int'(a[12:8]);
      oh = '0;
      if (slot < NUM_SLOTS) oh[slot] = 1'b1;
      k = 0; lat = 0; nwe = 0; nre = 0; nsel = 0; nbad = 0;
      got = 1'b0; err_s = 1'b0; rd_s = '0; s_wd = '0; s_addr = '0;
      @(negedge clk);
      for (int i = 0; i < NUM_SLOTS; i++)
         slv_read_data[i*DATA_WIDTH +: DATA_WIDTH] = (i == slot) ? sd : $urandom;
      slv_ready  = '0;
      address    = a;
      write_data = wd;
      we         = w;
      re         = r;
      while (!got && k < TIMEOUT + 8) begin
         @(negedge clk);
         k++;
         we = 1'b0;
         re = dup && (k == 3);
         if (slv_we) begin nwe++; s_addr = slv_address; s_wd = slv_write_data; end
         if (slv_re) begin nre++; s_addr = slv_address; end
         if (slv_sel != '0) begin
            if (slv_sel == oh) nsel++; else nbad++;
            if (!busy) nbad++;
         end
         if (error && !ready) nbad++;
         if (ready) begin got = 1'b1; lat = k; err_s = error; rd_s = read_data; end
         slv_ready = (16'($urandom) & ~oh) | ((k - 1 == waits) ? oh : 16'h0000);
      end
      we = 1'b0; re = 1'b0; slv_ready = '0;
      chk(tag, "ready_seen", 64'(got), 64'(1));
      chk(tag, "latency", 64'(lat), 64'(e_lat));
      chk(tag, "error", 64'(err_s), 64'(e_err));
      chk(tag, "read_data", 64'(rd_s), 64'(e_rd));
      chk(tag, "we_strobes", 64'(nwe), 64'(e_ext && w));
      chk(tag, "re_strobes", 64'(nre), 64'(e_ext && r));
      chk(tag, "sel_cycles", 64'(nsel), 64'(e_ext ? e_lat - 1 : 0));
      chk(tag, "bad_cycles", 64'(nbad), 64'(0));
      if (e_ext) chk(tag, "slv_address", 64'(s_addr), 64'(a[7:0]));
      if (e_ext && w) chk(tag, "slv_write_data", 64'(s_wd), 64'(wd));
      @(negedge clk);
      chk(tag, "ready_after", 64'(ready), 64'(0));
      chk(tag, "rd_hold", 64'(read_data), 64'(e_rd));
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, "outputs_zero",
          64'({read_data, ready, error, busy, slv_we, slv_re, slv_address} != '0) +
          64'(slv_sel) + 64'(slv_write_data), 64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1);
   end

   initial begin
      int          lat, nr;
      logic        e, ext;
      logic [31:0] rd;

      tbl[0]  = '{14'h0100, 1'b0, 1'b1, 32'h0,        0,    32'hCAFE0001, 2,  1'b0, 32'hCAFE0001, 1'b1};
      tbl[1]  = '{14'h0510, 1'b1, 1'b0, 32'h12345678, 7,    32'h0,        9,  1'b0, 32'h0,        1'b1};
      tbl[2]  = '{14'h0C00, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b1, 32'h0,        1'b0};
      tbl[3]  = '{14'h0000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h1,        1'b0};
      tbl[4]  = '{14'h0004, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h0C00,     1'b0};
      tbl[5]  = '{14'h0300, 1'b0, 1'b1, 32'h0,        1000, 32'h33333333, 65, 1'b1, 32'h0,        1'b1};
      tbl[6]  = '{14'h0000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h2,        1'b0};
      tbl[7]  = '{14'h0100, 1'b1, 1'b1, 32'h55,       0,    32'h0,        1,  1'b1, 32'h0,        1'b0};
      tbl[8]  = '{14'h0004, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h0100,     1'b0};
      tbl[9]  = '{14'h0008, 1'b1, 1'b0, 32'h1,        0,    32'h0,        1,  1'b0, 32'h0,        1'b0};
      tbl[10] = '{14'h0000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h0,        1'b0};
      tbl[11] = '{14'h0004, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h0,        1'b0};
      tbl[12] = '{14'h0900, 1'b0, 1'b1, 32'h0,        63,   32'h5A5A0009, 65, 1'b0, 32'h5A5A0009, 1'b1};
      tbl[13] = '{14'h1000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b1, 32'h0,        1'b0};
      tbl[14] = '{14'h0A00, 1'b1, 1'b0, 32'h77,       0,    32'h0,        1,  1'b1, 32'h0,        1'b0};
      tbl[15] = '{14'h0000, 1'b1, 1'b0, 32'hFFFFFFFF, 0,    32'h0,        1,  1'b0, 32'h0,        1'b0};
      tbl[16] = '{14'h0000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h2,        1'b0};
      tbl[17] = '{14'h0004, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h0A00,     1'b0};
      tbl[18] = '{14'h2100, 1'b0, 1'b1, 32'h0,        2,    32'h11112222, 4,  1'b0, 32'h11112222, 1'b1};
      tbl[19] = '{14'h0018, 1'b1, 1'b0, 32'h1,        0,    32'h0,        1,  1'b0, 32'h0,        1'b0};
      tbl[20] = '{14'h0000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h2,        1'b0};
      tbl[21] = '{14'h0008, 1'b1, 1'b0, 32'h2,        0,    32'h0,        1,  1'b0, 32'h0,        1'b0};
      tbl[22] = '{14'h0000, 1'b0, 1'b1, 32'h0,        0,    32'h0,        1,  1'b0, 32'h2,        1'b0};

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         model(tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].wd, tbl[i].waits, tbl[i].sd, lat, e, rd, ext);
         run_txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].wd, tbl[i].waits,
                 tbl[i].sd, 1'b0, tbl[i].lat, tbl[i].err, tbl[i].rd, tbl[i].ext);
      end

      // A second request while busy must not produce another strobe or response
      model(14'h0100, 1'b0, 1'b1, 32'h0, 5, 32'hABCD0001, lat, e, rd, ext);
      run_txn("busy_dup", 14'h0100, 1'b0, 1'b1, 32'h0, 5, 32'hABCD0001, 1'b1, lat, e, rd, ext);
      nr = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ready || slv_we || slv_re || slv_sel != '0) nr++;
      end
      chk("busy_dup", "extra_activity", 64'(nr), 64'(0));

      // Reset in the middle of an ACCESS wait
      @(negedge clk);
      address = 14'h0200; re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid", "busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_cnt = '0; m_addr = '0;
      nr = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ready || busy) nr++;
      end
      chk("rst_mid", "post_release_activity", 64'(nr), 64'(0));
      model(14'h0100, 1'b0, 1'b1, 32'h0, 0, 32'hCAFE0001, lat, e, rd, ext);
      run_txn("rst_after", 14'h0100, 1'b0, 1'b1, 32'h0, 0, 32'hCAFE0001, 1'b0, lat, e, rd, ext);

      // Randomized transactions against the reference model
      for (int it = 0; it < 300; it++) begin
         logic [13:0] a;
         logic        w, r;
         logic [31:0] wd, sd;
         int          waits, pick, mode;
         a    = 14'($urandom);
         pick = $urandom_range(0, 9);
         if (pick < 2) begin
            a[12:8] = 5'd0;
            case ($urandom_range(0, 3))
               0: a[7:0] = 8'h00;
               1: a[7:0] = 8'h04;
               2: a[7:0] = 8'h08;
               default: a[7:0] = 8'h10;
            endcase
         end else if (pick < 6) begin
            a[12:8] = 5'($urandom_range(1, 9));
         end
         mode = $urandom_range(0, 9);
         w = (mode == 0) || (mode >= 5);
         r = (mode < 5);
         waits = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 100) : $urandom_range(0, 6);
         wd = $urandom;
         sd = $urandom;
         model(a, w, r, wd, waits, sd, lat, e, rd, ext);
         run_txn($sformatf("rnd%0d", it), a, w, r, wd, waits, sd, 1'b0, lat, e, rd, ext);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/periph_interconnect.md
Name: periph_interconnect

Overview:
Parametrised peripheral interconnect that replaces the fixed single-cycle peripheral decoder. Decodes a slot field of the CPU peripheral address into one of NUM_SLOTS one-hot slave selects and issues a one-cycle strobe to the selected slave. Waits for a per-slave ready handshake, which supports multi-cycle peripherals such as the sequential multiplier and divider. Signals a bus error for unmapped slots, illegal requests and timeouts, and exposes error status through built-in registers in slot 0.

Parameters:
NUM_SLOTS, 16, number of decoded slots; slot 0 is internal status, slots 1..NUM_SLOTS-1 are external.
ADDR_WIDTH, 14, host address width.
DATA_WIDTH, 32, data width.
OFFS_BITS, 8, in-slot offset width; the slot field is address[OFFS_BITS+SLOT_BITS-1:OFFS_BITS].
SLOT_BITS, 5, slot field width; requires 2^SLOT_BITS >= NUM_SLOTS and OFFS_BITS+SLOT_BITS <= ADDR_WIDTH.
SLOT_MASK, 16'h03FE, bit i = 1 means external slot i is populated; bit 0 is ignored.
TIMEOUT, 64, maximum number of wait cycles for slv_ready; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  host address; sampled when the request is accepted
write_data  in  DATA_WIDTH  host write data
read_data  out  DATA_WIDTH  registered read data; valid while ready=1
we  in  1  write request, one-cycle pulse
re  in  1  read request, one-cycle pulse
ready  out  1  one-cycle transaction completion pulse
error  out  1  qualifies ready; 1 means a bus error occurred
busy  out  1  high from request acceptance until the ready cycle
slv_sel  out  NUM_SLOTS  one-hot select, held for the whole access
slv_we  out  1  write strobe, one cycle
slv_re  out  1  read strobe, one cycle
slv_address  out  OFFS_BITS  latched in-slot offset
slv_write_data  out  DATA_WIDTH  latched write data
slv_read_data  in  NUM_SLOTS*DATA_WIDTH  flattened slave read buses; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
slv_ready  in  NUM_SLOTS  per-slave completion; sampled only for the selected slot

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; read_data, ready, error, busy, slv_sel, slv_we, slv_re, slv_address, slv_write_data, ERR_COUNT and ERR_ADDR all clear to 0. Reset mid-transaction aborts the access; no completion pulse follows.
- State IDLE, on we^re (exactly one set):
  - Latch address, write_data and direction. Set busy.
  - Slot populated (SLOT_MASK bit set, slot < NUM_SLOTS, slot != 0): go to ACCESS.
  - Slot 0: go to RESP and perform the internal register access.
  - Otherwise: go to RESP with error=1.
- State IDLE, on we&re together: no slave access; go to RESP with error=1.
- Requests arriving while busy=1 are ignored; the host must wait for ready.
- State ACCESS:
  - slv_sel[slot]=1 throughout.
  - slv_we/slv_re high only in the first ACCESS cycle.
  - Wait counter clears on entry and increments each cycle slv_ready[slot]=0.
  - slv_ready[slot]=1 (this may occur in the strobe cycle itself): capture slv_read_data slice into read_data on reads (0 on writes); go to RESP with error=0.
  - Counter reaches TIMEOUT with ready still low: go to RESP with error=1. slv_sel drops on leaving ACCESS.
- State RESP: ready=1 for exactly one cycle; error valid; busy falls in the same cycle; go to IDLE. read_data is 0 on any error and holds its value until the next completion.
- Latency from request cycle T:
  - Zero-wait external slave: ready at T+2.
  - Internal or decode error: ready at T+1.
  - Timeout: ready at T+1+TIMEOUT.
- Internal registers (slot 0):
  - Offset 0x00 ERR_COUNT (RO): saturating DATA_WIDTH-bit error counter.
  - Offset 0x04 ERR_ADDR (RO): full host address of the most recent error, zero-extended.
  - Offset 0x08 CTRL (WO): bit0=1 clears ERR_COUNT and ERR_ADDR.
  - Other offsets: read 0, writes ignored, no error.
- ERR_COUNT increments and ERR_ADDR updates in the RESP cycle of every error response. ERR_COUNT holds at all-ones when saturated.

Test Plan:
- Read slot 1 with slv_ready[1]=1 in the strobe cycle and slice data 32'hCAFE0001 -> slv_re for 1 cycle, slv_sel=16'h0002, ready=1 and error=0 at T+2, read_data=32'hCAFE0001.
- Write 32'h12345678 to address 14'h0510 (slot 5), slave ready after 7 wait cycles -> slv_we for 1 cycle with slv_address=8'h10 and slv_write_data=32'h12345678; ready and error=0 at T+9.
- Read unmapped slot 12 -> ready and error=1 at T+1, no slave strobe, read_data=0, ERR_COUNT=1, ERR_ADDR=14'h0C00.
- Read slot 3 with slv_ready never asserted, TIMEOUT=64 -> ready and error=1 at T+65, slv_sel[3] high for 64 cycles, ERR_COUNT increments.
- we&re together to slot 1, then write CTRL=1 -> first response has error=1; after the CTRL write, ERR_COUNT reads 0; a second request issued while busy=1 causes no additional strobe.
- rst_n pulled low during the ACCESS wait -> all outputs 0 immediately; no ready pulse after release; next read to slot 1 completes normally.
